// File: rtl/pwm_dac.sv
// pwm_dac: FIFO-buffered sink that plays each unsigned 8-bit sample as one 256-tick PWM frame.
// Build option UNDERRUN_HOLD_EN: on underrun the previous duty repeats instead of loading midscale.
module pwm_dac #(
    parameter int DEPTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   en,
    input  logic [7:0]             sample,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   sample_req,
    output logic                   underrun,
    output logic                   pwm_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [AW:0]   FILL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   FILL_ZERO = (AW + 1)'(0);
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRE_ZERO  = PW'(0);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_fill;
    logic            r_ready;
    logic [PW-1:0]   r_pre;
    logic [7:0]      r_cnt;
    logic [7:0]      r_duty;
    logic            r_req;
    logic            r_underrun;
    logic            r_pwm;

    state_t          w_state_next;
    logic [PW-1:0]   w_pre_next;
    logic [7:0]      w_cnt_next;
    logic [7:0]      w_duty_next;
    logic [AW:0]     w_fill_next;
    logic            w_tick;
    logic            w_frame_start;
    logic            w_push;
    logic            w_pop;
    logic            w_pwm_next;

    // Next-state, frame timing, FIFO handshake and duty selection.
    always_comb begin
        w_state_next  = r_state;
        w_pre_next    = r_pre;
        w_cnt_next    = r_cnt;
        w_duty_next   = r_duty;
        w_fill_next   = r_fill;
        w_frame_start = 1'b0;
        w_tick        = (r_pre == PRE_LAST);

        case (r_state)
            IDLE: begin
                w_pre_next = PRE_ZERO;
                w_cnt_next = 8'd0;
                if (en) begin
                    w_state_next  = RUN;
                    w_frame_start = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (!en) begin
                    w_state_next = IDLE;
                    w_pre_next   = PRE_ZERO;
                    w_cnt_next   = 8'd0;
                end else if (w_tick) begin
                    w_pre_next    = PRE_ZERO;
                    w_cnt_next    = r_cnt + 8'd1;
                    w_frame_start = (r_cnt == 8'd255);
                end else begin
                    w_pre_next = r_pre + PW'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
                w_pre_next   = PRE_ZERO;
                w_cnt_next   = 8'd0;
            end
        endcase

        w_push = sample_valid && r_ready;
        w_pop  = w_frame_start && (r_fill != FILL_ZERO);

        if (w_pop) begin
            w_duty_next = r_mem[r_rd_ptr];
        end else if (w_frame_start) begin
`ifdef UNDERRUN_HOLD_EN
            w_duty_next = r_duty;
`else
            w_duty_next = 8'd128;
`endif
        end else begin
            w_duty_next = r_duty;
        end

        case ({w_push, w_pop})
            2'b10:   w_fill_next = r_fill + (AW + 1)'(1);
            2'b01:   w_fill_next = r_fill - (AW + 1)'(1);
            default: w_fill_next = r_fill;
        endcase

        w_pwm_next = (w_state_next == RUN) && en && (w_cnt_next < w_duty_next);
    end

    // Control, pointer and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_fill     <= FILL_ZERO;
            r_ready    <= 1'b1;
            r_pre      <= PRE_ZERO;
            r_cnt      <= 8'd0;
            r_duty     <= 8'd0;
            r_req      <= 1'b0;
            r_underrun <= 1'b0;
            r_pwm      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wr_ptr   <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
            r_rd_ptr   <= w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
            r_fill     <= w_fill_next;
            r_ready    <= (w_fill_next != FILL_FULL);
            r_pre      <= w_pre_next;
            r_cnt      <= w_cnt_next;
            r_duty     <= w_duty_next;
            r_req      <= w_frame_start;
            r_underrun <= w_frame_start && !w_pop;
            r_pwm      <= w_pwm_next;
        end
    end

    // Sample storage; no reset needed since occupancy is tracked by r_fill.
    always_ff @(posedge clk) begin
        if (n_rst && w_push) begin
            r_mem[r_wr_ptr] <= sample;
        end
    end

    assign sample_ready = r_ready;
    assign fill         = r_fill;
    assign sample_req   = r_req;
    assign underrun     = r_underrun;
    assign pwm_out      = r_pwm;

endmodule

// File: tb/tb_pwm_dac.sv
// Directed bench for pwm_dac: one instance at PRESCALE=1 for the main scenarios, one at PRESCALE=3.
module tb_pwm_dac;
`ifdef UNDERRUN_HOLD_EN
    localparam int EXP_UR_F5   = 200;
    localparam int EXP_UR_F40  = 40;
    localparam int EXP_UR_RST  = 0;
    localparam int EXP_UR_P3   = 30;
`else
    localparam int EXP_UR_F5   = 128;
    localparam int EXP_UR_F40  = 128;
    localparam int EXP_UR_RST  = 128;
    localparam int EXP_UR_P3   = 384;
`endif

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] sample = 8'd0;
    logic       sample_valid = 1'b0;
    logic       sample_ready;
    logic [2:0] fill;
    logic       sample_req;
    logic       underrun;
    logic       pwm_out;

    logic       n_rst3 = 1'b0;
    logic       en3 = 1'b0;
    logic [7:0] sample3 = 8'd0;
    logic       valid3 = 1'b0;
    logic       ready3;
    logic [2:0] fill3;
    logic       req3;
    logic       ur3;
    logic       pwm3;

    int n_total = 0;
    int n_bad   = 0;

    pwm_dac #(.DEPTH(4), .PRESCALE(1)) u_dut (
        .clk(clk), .n_rst(n_rst), .en(en), .sample(sample), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .fill(fill), .sample_req(sample_req),
        .underrun(underrun), .pwm_out(pwm_out)
    );

    pwm_dac #(.DEPTH(4), .PRESCALE(3)) u_dut3 (
        .clk(clk), .n_rst(n_rst3), .en(en3), .sample(sample3), .sample_valid(valid3),
        .sample_ready(ready3), .fill(fill3), .sample_req(req3),
        .underrun(ur3), .pwm_out(pwm3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        sample       = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    // One 256-cycle window starting at the frame-start edge; optional push mid-frame.
    task automatic frame_chk(input string tag, input bit pe, input logic [7:0] pv,
                             input int exp_hi, input int exp_ur, input int exp_f0);
        int hi = 0;
        int rq = 0;
        int ur = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (i == 0) begin
                chk({tag, "_req0"},   int'(sample_req),   1);
                chk({tag, "_fill0"},  int'(fill),         exp_f0);
                chk({tag, "_ready0"}, int'(sample_ready), 1);
            end
            hi += int'(pwm_out);
            rq += int'(sample_req);
            ur += int'(underrun);
            if (pe && i == 10) begin
                sample       = pv;
                sample_valid = 1'b1;
            end
            if (i == 11) sample_valid = 1'b0;
        end
        chk({tag, "_high"}, hi, exp_hi);
        chk({tag, "_reqs"}, rq, 1);
        chk({tag, "_ur"},   ur, exp_ur);
    endtask

    initial begin
        int hi;
        int rq;
        int ur;

        // Reset, with a push presented during reset that must be dropped.
        sample       = 8'd77;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        chk("rst_fill",  int'(fill),         0);
        chk("rst_ready", int'(sample_ready), 1);
        chk("rst_pwm",   int'(pwm_out),      0);
        chk("rst_req",   int'(sample_req),   0);
        chk("rst_ur",    int'(underrun),     0);
        n_rst = 1'b1;
        tick();
        chk("rst_push_dropped", int'(fill), 0);

        // Basic frames: 64, 0, 255, then push/underrun sequencing.
        push(8'd64);
        chk("push1_fill", int'(fill), 1);
        push(8'd0);
        push(8'd255);
        chk("push3_fill", int'(fill), 3);
        en = 1'b1;
        frame_chk("f64",  1'b0, 8'd0,   64,        0, 2);
        frame_chk("f0",   1'b0, 8'd0,   0,         0, 1);
        frame_chk("f255", 1'b1, 8'd200, 255,       0, 0);
        frame_chk("f200", 1'b0, 8'd0,   200,       0, 0);
        frame_chk("fur",  1'b1, 8'd33,  EXP_UR_F5, 1, 0);
        frame_chk("f33",  1'b0, 8'd0,   33,        0, 0);

        // Fill while disabled; the fifth push must be dropped.
        en = 1'b0;
        tick();
        chk("dis_pwm", int'(pwm_out), 0);
        push(8'd10);
        push(8'd20);
        push(8'd30);
        push(8'd40);
        chk("full_fill",  int'(fill),         4);
        chk("full_ready", int'(sample_ready), 0);
        push(8'd50);
        chk("full_drop_fill", int'(fill), 4);
        en = 1'b1;
        frame_chk("q10",  1'b0, 8'd0, 10,         0, 3);
        frame_chk("q20",  1'b0, 8'd0, 20,         0, 2);
        frame_chk("q30",  1'b0, 8'd0, 30,         0, 1);
        frame_chk("q40",  1'b0, 8'd0, 40,         0, 0);
        frame_chk("q_ur", 1'b0, 8'd0, EXP_UR_F40, 1, 0);

        // Abandon a duty=150 frame at cnt=100, re-enable 10 cycles later.
        en = 1'b0;
        tick();
        push(8'd150);
        push(8'd77);
        en = 1'b1;
        for (int i = 0; i < 101; i++) tick();
        chk("mid_pwm_hi", int'(pwm_out), 1);
        en = 1'b0;
        tick();
        chk("mid_pwm_off", int'(pwm_out), 0);
        for (int i = 0; i < 9; i++) tick();
        chk("mid_pwm_idle", int'(pwm_out), 0);
        chk("mid_fill",     int'(fill),    1);
        en = 1'b1;
        frame_chk("resume77", 1'b0, 8'd0, 77, 0, 0);

        // Reset mid-frame with fill=3 and a push in the reset cycle.
        push(8'd1);
        push(8'd2);
        push(8'd3);
        chk("pre_rst_fill", int'(fill), 3);
        for (int i = 0; i < 5; i++) tick();
        n_rst        = 1'b0;
        sample       = 8'd99;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        n_rst        = 1'b1;
        chk("mrst_fill",  int'(fill),         0);
        chk("mrst_pwm",   int'(pwm_out),      0);
        chk("mrst_ready", int'(sample_ready), 1);
        chk("mrst_req",   int'(sample_req),   0);
        frame_chk("post_rst", 1'b0, 8'd0, EXP_UR_RST, 1, 0);
        en = 1'b0;

        // PRESCALE=3 instance: duty 10 then an underrun frame.
        n_rst3 = 1'b1;
        sample3 = 8'd10;
        valid3  = 1'b1;
        tick();
        valid3  = 1'b0;
        chk("p3_fill", int'(fill3), 1);
        en3 = 1'b1;
        for (int f = 0; f < 2; f++) begin
            hi = 0;
            rq = 0;
            ur = 0;
            for (int i = 0; i < 768; i++) begin
                tick();
                hi += int'(pwm3);
                rq += int'(req3);
                ur += int'(ur3);
            end
            chk(f == 0 ? "p3_high" : "p3_ur_high", hi, (f == 0) ? 30 : EXP_UR_P3);
            chk(f == 0 ? "p3_reqs" : "p3_ur_reqs", rq, 1);
            chk(f == 0 ? "p3_ur"   : "p3_ur_ur",   ur, f);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
